// File: rtl/rgst_seq_shifter.sv
// Parallel-load register that executes multi-bit shifts/rotates one bit per clock
// under a start/busy/done handshake; includes the SRT-2 skip-LSb left shift.
module rgst_seq_shifter #(
  parameter int WIDTH   = 9,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               shift_out,
  output logic               busy,
  output logic               done,
  output logic [SHAMT_W-1:0] count
);

  typedef enum logic [2:0] {
    OP_LOAD     = 3'b000,
    OP_LSL      = 3'b001,
    OP_LSR      = 3'b010,
    OP_ASR      = 3'b011,
    OP_ROL      = 3'b100,
    OP_ROR      = 3'b101,
    OP_LSL_SKIP = 3'b110,
    OP_NOP      = 3'b111
  } op_e;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               so_q, so_d;
  logic               done_q, done_d;
  logic [SHAMT_W-1:0] count_q, count_d;

  // One single-bit step of the latched operation; returns {shift_out, data}.
  function automatic logic [WIDTH:0] step(input op_e o, input logic [WIDTH-1:0] b,
                                          input logic si);
    logic [WIDTH:0] r;
    r = {1'b0, b};
    case (o)
      OP_LSL:      r = {b[WIDTH-1], b[WIDTH-2:0], si};
      OP_LSR:      r = {b[0], si, b[WIDTH-1:1]};
      OP_ASR:      r = {b[0], b[WIDTH-1], b[WIDTH-1:1]};
      OP_ROL:      r = {b[WIDTH-1], b[WIDTH-2:0], b[WIDTH-1]};
      OP_ROR:      r = {b[0], b[0], b[WIDTH-1:1]};
      // SRT-2: bit 1 takes serial_in instead of the old LSb.
      OP_LSL_SKIP: r = {b[WIDTH-1], b[WIDTH-2:1], si, si};
      default:     r = {1'b0, b};
    endcase
    return r;
  endfunction

  // NOTE: every next-state variable gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    so_d    = so_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_LOAD: begin
              data_d = data_in;
              done_d = 1'b1;
            end
            OP_NOP: done_d = 1'b1;
            default: begin
              if (shamt == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = op_e'(op);
                count_d = shamt;
                state_d = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        {so_d, data_d} = step(op_q, data_q, serial_in);
        count_d        = count_q - 1'b1;
        if (count_q == SHAMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; the comb block above uses blocking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      so_q    <= so_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign data_out  = data_q;
  assign shift_out = so_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign count     = count_q;

endmodule
